prf_wb_arbiter: RTL

//  Parametrised writeback front-end for the banked PRF. Each write requestor (WR) gets a small FIFO
//  for writeback packets. Each cycle, every bank grants one FIFO head that maps to it, round-robin.
//  The result drives one registered WB bus per bank, which feeds the PRF bank write port and forwarding.

---
 rtl/prf_wb_arbiter_pkg.sv | 20 ++
 rtl/prf_wb_arbiter_rr_arb.sv | 55 +++++
 rtl/prf_wb_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/prf_wb_arbiter_pkg.sv
// Shared core types for the PRF writeback front-end: default geometry and the
// writeback packet stored in each requestor FIFO.
package core_types_pkg;

  localparam int PRF_WR_COUNT       = 4;
  localparam int PRF_BANK_COUNT     = 4;
  localparam int PR_COUNT           = 128;
  localparam int ROB_ENTRIES        = 128;
  localparam int WB_DATA_WIDTH      = 32;
  localparam int LOG_PR_COUNT       = $clog2(PR_COUNT);
  localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
  localparam int LOG_ROB_ENTRIES    = $clog2(ROB_ENTRIES);

  typedef struct packed {
    logic [WB_DATA_WIDTH-1:0]   data;
    logic [LOG_PR_COUNT-1:0]    PR;
    logic [LOG_ROB_ENTRIES-1:0] ROB_index;
  } wb_pkt_t;

endpackage

// File: rtl/prf_wb_arbiter_rr_arb.sv
// N-way round-robin arbiter: one-hot grant searched upward from (ptr+1) mod N;
// the pointer moves to the winner on every grant and holds otherwise.
module prf_wb_rr_arb #(
  parameter int N = 4
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt,
  output logic         o_any
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_winner;
  logic [PW-1:0] w_idx;
  logic          w_found;
  int            w_pos;

  // First requester at or after (ptr+1), wrapping upward.
  always_comb begin
    o_gnt    = '0;
    w_winner = r_ptr;
    w_found  = 1'b0;
    w_pos    = 0;
    w_idx    = '0;
    for (int i = 0; i < N; i++) begin
      w_pos = int'(r_ptr) + 1 + i;
      w_pos = (w_pos >= N) ? (w_pos - N) : w_pos;
      w_idx = PW'(w_pos);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_winner     = w_idx;
        w_found      = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

  assign o_any = |i_req;

  // Reset value N-1 gives requestor 0 first priority.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ptr <= PW'(N - 1);
    end else if (o_any) begin
      r_ptr <= w_winner;
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/prf_wb_arbiter.sv
// Banked PRF writeback front-end: per-requestor packet FIFOs feeding one
// round-robin arbiter and one registered writeback bus per PRF bank.
module prf_wb_arbiter
  import core_types_pkg::*;
#(
  parameter int WR_COUNT    = PRF_WR_COUNT,
  parameter int BANK_COUNT  = PRF_BANK_COUNT,
  parameter int PR_COUNT    = core_types_pkg::PR_COUNT,
  parameter int ROB_ENTRIES = core_types_pkg::ROB_ENTRIES,
  parameter int DATA_WIDTH  = WB_DATA_WIDTH,
  parameter int FIFO_DEPTH  = 2,
  localparam int LOG_PR     = $clog2(PR_COUNT),
  localparam int LOG_BANK   = $clog2(BANK_COUNT),
  localparam int LOG_ROB    = $clog2(ROB_ENTRIES),
  localparam int UPR_W      = LOG_PR - LOG_BANK
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic [WR_COUNT-1:0]              WB_valid_by_wr,
  input  logic [WR_COUNT*DATA_WIDTH-1:0]   WB_data_by_wr,
  input  logic [WR_COUNT*LOG_PR-1:0]       WB_PR_by_wr,
  input  logic [WR_COUNT*LOG_ROB-1:0]      WB_ROB_index_by_wr,
  output logic [WR_COUNT-1:0]              WB_ready_by_wr,
  output logic [BANK_COUNT-1:0]            WB_bus_valid_by_bank,
  output logic [BANK_COUNT*DATA_WIDTH-1:0] WB_bus_data_by_bank,
  output logic [BANK_COUNT*UPR_W-1:0]      WB_bus_upper_PR_by_bank,
  output logic [BANK_COUNT*LOG_ROB-1:0]    WB_bus_ROB_index_by_bank
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  wb_pkt_t             w_head [WR_COUNT];
  logic [WR_COUNT-1:0] w_nonempty;
  logic [WR_COUNT-1:0] w_pop;
  logic [WR_COUNT-1:0] w_req  [BANK_COUNT];
  logic [WR_COUNT-1:0] w_gnt  [BANK_COUNT];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == FIFO_DEPTH - 1) ? '0 : (p + PTR_W'(1));
  endfunction

  for (genvar w = 0; w < WR_COUNT; w++) begin : g_wr
    wb_pkt_t          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    wb_pkt_t          w_in;

    // Ready looks only at the registered count, never at this cycle's pop.
    assign WB_ready_by_wr[w] = (r_count < CNT_W'(FIFO_DEPTH));
    assign w_push            = WB_valid_by_wr[w] & WB_ready_by_wr[w];
    assign w_nonempty[w]     = (r_count != '0);
    assign w_head[w]         = r_mem[r_rd_ptr];
    assign w_in.data         = WB_data_by_wr[w*DATA_WIDTH +: DATA_WIDTH];
    assign w_in.PR           = WB_PR_by_wr[w*LOG_PR +: LOG_PR];
    assign w_in.ROB_index    = WB_ROB_index_by_wr[w*LOG_ROB +: LOG_ROB];

    // Packet storage; contents need no reset since count gates every read.
    always_ff @(posedge CLK) begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_in;
      end
    end

    // Circular pointers and occupancy.
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_pop[w]) r_rd_ptr <= ptr_inc(r_rd_ptr);
        case ({w_push, w_pop[w]})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Request matrix: a head requests only the bank selected by its low PR bits.
  always_comb begin
    for (int b = 0; b < BANK_COUNT; b++) begin
      for (int w = 0; w < WR_COUNT; w++) begin
        w_req[b][w] = w_nonempty[w] && (w_head[w].PR[LOG_BANK-1:0] == LOG_BANK'(b));
      end
    end
  end

  // A head maps to one bank only, so at most one grant bit per WR is set.
  always_comb begin
    w_pop = '0;
    for (int b = 0; b < BANK_COUNT; b++) begin
      w_pop = w_pop | w_gnt[b];
    end
  end

  for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
    logic                  w_any;
    wb_pkt_t               w_sel;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [UPR_W-1:0]      r_upper_pr;
    logic [LOG_ROB-1:0]    r_rob;

    prf_wb_rr_arb #(.N(WR_COUNT)) u_arb (
      .CLK   (CLK),
      .nRST  (nRST),
      .i_req (w_req[b]),
      .o_gnt (w_gnt[b]),
      .o_any (w_any)
    );

    // One-hot AND-OR mux of the winning head.
    always_comb begin
      w_sel = '0;
      for (int w = 0; w < WR_COUNT; w++) begin
        w_sel = w_sel | (w_gnt[b][w] ? w_head[w] : '0);
      end
    end

    // Bus payload changes only on a grant.
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        r_valid    <= 1'b0;
        r_data     <= '0;
        r_upper_pr <= '0;
        r_rob      <= '0;
      end else begin
        r_valid <= w_any;
        if (w_any) begin
          r_data     <= w_sel.data;
          r_upper_pr <= w_sel.PR[LOG_PR-1:LOG_BANK];
          r_rob      <= w_sel.ROB_index;
        end
      end
    end

    assign WB_bus_valid_by_bank[b]                      = r_valid;
    assign WB_bus_data_by_bank[b*DATA_WIDTH +: DATA_WIDTH] = r_data;
    assign WB_bus_upper_PR_by_bank[b*UPR_W +: UPR_W]    = r_upper_pr;
    assign WB_bus_ROB_index_by_bank[b*LOG_ROB +: LOG_ROB] = r_rob;
  end

endmodule
